// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, one outstanding imem request, and a
// one-entry output buffer feeding the IF/ID register.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;

  logic        w_buf_free;
  logic        w_req;
  logic        w_fill;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;

  assign w_buf_free    = ~r_valid | ~stall;
  assign w_redirect_pc = word_align(redirect_pc);
  assign w_pc_plus4    = r_pc + 32'd4;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_REQ: begin
        if (w_req && imem_gnt) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_state_next = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          w_state_next = S_REQ;
        end
      end
      S_DROP: begin
        // The orphaned response retires the drop even if another redirect lands.
        if (imem_rvalid) begin
          w_state_next = S_REQ;
        end
      end
      default: w_state_next = S_REQ;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_req  = 1'b0;
    w_fill = 1'b0;
    case (r_state)
      S_REQ:   w_req  = w_buf_free & ~redirect;
      S_WAIT:  w_fill = imem_rvalid & ~redirect;
      default: begin
        w_req  = 1'b0;
        w_fill = 1'b0;
      end
    endcase
  end

  // PC and output buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
    end else if (redirect) begin
      r_pc       <= w_redirect_pc;
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
    end else if (w_fill) begin
      // Refill takes priority over a same-cycle consume.
      r_pc       <= w_pc_plus4;
      r_valid    <= 1'b1;
      r_instr    <= imem_rdata;
      r_pc_plus4 <= w_pc_plus4;
    end else if (r_valid && !stall) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
    end
  end

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign valid_out    = r_valid;
  assign instr_out    = r_instr;
  assign pc_plus4_out = r_pc_plus4;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch front end that produces the {pc_plus4, instr} pair consumed by the IF/ID pipeline register. It owns the PC and a one-outstanding-request handshake to instruction memory. It holds a one-entry output buffer under decode-side stall and discards in-flight fetches on a branch/jump redirect. The IF/ID register loads when valid_out=1 and stall=0, and is flushed by the same redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word driven when valid_out=0 (sll $0,$0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: downstream cannot accept this cycle
redirect  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  new PC target; bits [1:0] ignored, treated as 00
imem_req  out  1  fetch request valid
imem_addr  out  32  word-aligned fetch address (= pc)
imem_gnt  in  1  request accepted this cycle (req & gnt = handshake)
imem_rvalid  in  1  response data valid; at least 1 cycle after gnt
imem_rdata  in  32  fetched instruction
valid_out  out  1  output buffer holds a valid instruction
instr_out  out  32  buffered instruction; NOP_INSTR when valid_out=0
pc_plus4_out  out  32  address of buffered instruction + 4; 0 when valid_out=0

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Priority: reset > redirect > normal operation.
- Reset values: pc=RESET_PC, state=S_REQ, valid_out=0, instr_out=NOP_INSTR, pc_plus4_out=0. imem_req is combinational and may assert in the first cycle after reset.
- Reset asserted mid-transaction: state returns to S_REQ. Any later imem_rvalid belonging to the abandoned request is ignored. The memory must not return data for a request granted before reset (system contract).
- Exactly one request outstanding at any time.
- buf_free = (valid_out==0) | (stall==0).
- S_REQ:
  - imem_req = buf_free & ~redirect; imem_addr = pc.
  - On req & gnt: go to S_WAIT.
  - On redirect: pc <= {redirect_pc[31:2],2'b00}; stay in S_REQ; no request that cycle.
- S_WAIT:
  - imem_req=0.
  - On rvalid & ~redirect: instr_out <= rdata; pc_plus4_out <= pc+4; valid_out <= 1; pc <= pc+4; go to S_REQ.
  - On redirect (with or without rvalid): pc <= redirect_pc.
    - If rvalid is also high this cycle: word discarded; go to S_REQ.
    - Otherwise: go to S_DROP.
- S_DROP:
  - imem_req=0; waits for the orphaned response.
  - On rvalid: data discarded; go to S_REQ.
  - A further redirect while in S_DROP updates pc and stays in S_DROP.
- Output buffer:
  - Consumed when valid_out & ~stall. Then valid_out <= 0 unless refilled in the same cycle (refill wins).
  - While stall=1 and valid_out=1, instr_out and pc_plus4_out hold stable.
  - Any redirect clears it: valid_out <= 0, instr_out <= NOP_INSTR, pc_plus4_out <= 0, effective next cycle.
- Buffer overrun cannot occur: a request issues only when buf_free, and the response arrives at least 1 cycle later.
- Arithmetic: pc+4 is modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000. pc[1:0] is always 00.
- Throughput: maximum one instruction every 2 cycles (request cycle, then response cycle). Fetch latency = gnt wait + memory latency + 1 register stage.

Decomposition:
- Shared package fetch_pkg: RESET_PC default, NOP_INSTR, and state encodings S_REQ=2'd0, S_WAIT=2'd1, S_DROP=2'd2.
- Single module; no sub-module is warranted. The PC register is inline.

Test Plan:
1. Reset, RESET_PC=0 -> next cycle imem_req=1, imem_addr=0x0, valid_out=0, instr_out=0x0.
2. Immediate gnt, rvalid one cycle later with rdata=0x20080005 -> valid_out=1, instr_out=0x20080005, pc_plus4_out=0x4; next imem_addr=0x4.
3. valid_out=1 with stall=1 for 3 cycles -> outputs stable, imem_req=0; stall drops -> request at pc+4 issued that cycle, and valid_out=0 on the following cycle.
4. Redirect to 0x40 while in S_WAIT -> valid_out=0 next cycle, S_DROP; the following rvalid (0xDEADBEEF) does not appear on instr_out; next imem_addr=0x40.
5. Redirect to 0x80 in the same cycle as rvalid -> word dropped, state S_REQ, imem_addr=0x80. Redirect coinciding with gnt in S_REQ -> no request that cycle; fetch from the new PC.
6. pc=0xFFFF_FFFC fetch -> pc_plus4_out=0x0000_0000, next imem_addr=0x0. Reset asserted while in S_DROP -> S_REQ, pc=RESET_PC.
